inv_key_sched: RTL and testbench
================================

// Module: inv_key_sched
// PURPOSE
//  AES-128 inverse key schedule: the decryption-side counterpart of the forward key expansion.
//  - Input: the final round key (round NR).
//  - Output: round keys NR, NR-1, ..., 0, in descending order, one per valid/ready transfer.
//  - Feeds the decryption core, which consumes round keys in reverse.
//  - Round constants are generated on the fly by inverse xtime, not looked up.
// PARAMETERS
//  NR         10     number of rounds; AES-128 only; sets the initial round count
//  RCON_LAST  8'h36  Rcon(NR), loaded at start; comes from aes_pkg::RCON_AES128_LAST
// PORTS
//  clk        in   1    system clock, rising edge
//  n_rst      in   1    asynchronous, active-low reset
//  start      in   1    pulse: begin a schedule run using last_key
//  last_key   in   128  round-NR key; [127:96]=w0 ... [31:0]=w3 (FIPS-197 byte order)
//  key_out    out  128  current round key, same word order as last_key
//  round_out  out  4    round index of key_out (NR down to 0)
//  key_valid  out  1    key_out/round_out are valid
//  key_ready  in   1    consumer accepts key_out this cycle
//  busy       out  1    high from the cycle after start is accepted until the run completes
//  done       out  1    one-cycle pulse after round 0 is accepted
// BEHAVIOUR
//  - Reset values (n_rst low, async): state=IDLE; key_out=0, round_out=0, key_valid=0, busy=0,
//    done=0; rcon register=8'h00.
//  - FSM states: IDLE, EMIT.
//    - IDLE: start=1 latches key_out<=last_key, round_out<=NR, rcon<=RCON_LAST, goes to EMIT.
//    - EMIT: key_valid=1, busy=1. key_valid rises the cycle after start (latency 1).
//    - EMIT, key_valid & key_ready, round_out!=0: key_out<=prev(key_out), round_out--,
//      rcon<=inv_xtime(rcon); stays in EMIT (back-to-back, 1 key per cycle).
//    - EMIT, key_valid & key_ready, round_out==0: goes to IDLE; done=1 for one cycle;
//      key_valid=0 in the same cycle as done.
//  - prev(): with current words w0..w3, the previous-round words p0..p3 are:
//    - p3=w3^w2; p2=w2^w1; p1=w1^w0
//    - p0=w0^SubWord(RotWord(p3))^{rcon,24'h0}
//    - RotWord(a,b,c,d)=(b,c,d,a)
//    - The rcon in use is the current round's Rcon(round_out).
//  - inv_xtime(r): r[0]? (((r^8'h1B)>>1)|8'h80) : (r>>1)
//    - Sequence from 8'h36: 1B,80,40,20,10,08,04,02,01.
//    - The rcon value after round 1 is don't-care.
//  - Backpressure: while key_valid=1 and key_ready=0, key_out, round_out and rcon hold
//    stable; no combinational path from key_ready to key_valid.
//  - start while busy: ignored; last_key is not sampled.
//  - start in the same cycle as the done pulse (state already IDLE next cycle): accepted on
//    the following cycle only, i.e. start must be seen in IDLE.
//  - n_rst asserted mid-run: aborts immediately to reset values; no done pulse; next run
//    needs a fresh start.
//  - All XOR/S-box logic is combinational from registered key_out; one S-box layer
//    (4 lookups) per cycle.
// STRUCTURE
//  - aes_pkg (shared):
//    - AES128_KEY_W=128, AES_WORD_W=32, RCON_AES128_LAST=8'h36
//    - typedef aes_word_t
//    - function inv_xtime
//    - typedef enum {IDLE,EMIT} iks_state_t
//  - Sub-module sub_word: 32-bit SubWord built from four instances of the existing forward
//    sbox; instantiated once here, reusable by the forward key scheduler.
//  - Registers: state, key_out, round_out, rcon, done.
// TESTING
//  - Reset: hold n_rst=0 with random inputs -> all outputs 0; release; no key_valid without
//    start.
//  - FIPS-197 A.1 (key 2b7e151628aed2a6abf7158809cf4f3c), key_ready tied 1,
//    last_key=d014f9a8c9ee2589e13f0cc8b6630ca6:
//    - round 10 key appears 1 cycle after start;
//    - round 9 = ac7766f319fadc2128d12941575c006e;
//    - round 1 = a0fafe1788542cb123a339392a6c7605;
//    - round 0 = 2b7e1516...09cf4f3c;
//    - done pulses one cycle after round 0 is accepted; 11 keys over 11 consecutive cycles.
//  - Random key_ready stalls on the same vector -> identical key sequence; outputs stable
//    during stalls; round_out strictly 10..0 with no skips.
//  - start pulsed mid-run with a different last_key -> ignored; original sequence completes.
//  - n_rst pulsed while round_out=5 -> outputs return to reset values, no done; a new start
//    replays correctly from round 10.
//  - Self-check: a forward-expansion model on 100 random keys -> reverse sequence matches
//    the model exactly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, last AES-128 round constant, inverse xtime and schedule states.
package aes_pkg;
  localparam int AES128_KEY_W = 128;
  localparam int AES_WORD_W = 32;
  localparam logic [7:0] RCON_AES128_LAST = 8'h36;

  typedef logic [AES_WORD_W-1:0] aes_word_t;

  typedef enum logic [0:0] {IDLE, EMIT} iks_state_t;

  // Steps a round constant backwards: divides by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? (((r ^ 8'h1B) >> 1) | 8'h80) : (r >> 1);
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a constant table, purely combinational.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit offset is (255 - i_byte) * 8.
  logic [10:0] w_base;
  assign w_base = {~i_byte, 3'b000};
  assign o_byte = SBOX_TBL[w_base +: 8];
endmodule

// File: rtl/sub_word.sv
// 32-bit SubWord: four parallel forward S-box lookups, combinational.
module sub_word
  import aes_pkg::*;
(
  input  aes_word_t i_word,
  output aes_word_t o_word
);
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte(i_word[8*g +: 8]),
      .o_byte(o_word[8*g +: 8])
    );
  end
endmodule

// File: rtl/inv_key_sched.sv
// AES-128 inverse key schedule: emits round keys NR..0 one per valid/ready handshake.
// First key valid one cycle after start; key, round and rcon hold while the consumer stalls.
module inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter logic [7:0] RCON_LAST = RCON_AES128_LAST
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic [AES128_KEY_W-1:0] last_key,
  output logic [AES128_KEY_W-1:0] key_out,
  output logic [3:0]              round_out,
  output logic                    key_valid,
  input  logic                    key_ready,
  output logic                    busy,
  output logic                    done
);
  iks_state_t r_state, w_state_nxt;
  logic [AES128_KEY_W-1:0] r_key;
  logic [3:0] r_round;
  logic [7:0] r_rcon;
  logic r_done;

  aes_word_t w_w0, w_w1, w_w2, w_w3, w_p0, w_p1, w_p2, w_p3, w_sub;
  logic w_accept, w_last;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_p3 = w_w3 ^ w_w2;
  assign w_p2 = w_w2 ^ w_w1;
  assign w_p1 = w_w1 ^ w_w0;

  // SubWord(RotWord(p3)); the round constant is the one belonging to the key on the output.
  sub_word u_sub_word (
    .i_word({w_p3[23:0], w_p3[31:24]}),
    .o_word(w_sub)
  );
  assign w_p0 = w_w0 ^ w_sub ^ {r_rcon, 24'h0};

  assign w_accept = (r_state == EMIT) && key_ready;
  assign w_last   = (r_round == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = EMIT;
      EMIT:    if (w_accept && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_key   <= '0;
      r_round <= '0;
      r_rcon  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_accept && w_last;
      if (r_state == IDLE && start) begin
        r_key   <= last_key;
        r_round <= 4'(NR);
        r_rcon  <= RCON_LAST;
      end else if (w_accept && !w_last) begin
        r_key   <= {w_p0, w_p1, w_p2, w_p3};
        r_round <= r_round - 4'd1;
        r_rcon  <= inv_xtime(r_rcon);
      end
    end
  end

  assign key_out   = r_key;
  assign round_out = r_round;
  assign key_valid = (r_state == EMIT);
  assign busy      = (r_state == EMIT);
  assign done      = r_done;
endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched: forward AES-128 expansion model, reversed, checked against the DUT.
module tb_inv_key_sched;
  logic         clk = 1'b0;
  logic         n_rst, start, key_ready;
  logic [127:0] last_key, key_out;
  logic [3:0]   round_out;
  logic         key_valid, busy, done;

  int total = 0;
  int bad = 0;
  logic [7:0]   sb[256];
  logic [127:0] rk[11];
  logic [127:0] obs[11];

  always #5 clk = ~clk;

  inv_key_sched dut (
    .clk(clk), .n_rst(n_rst), .start(start), .last_key(last_key),
    .key_out(key_out), .round_out(round_out), .key_valid(key_valid),
    .key_ready(key_ready), .busy(busy), .done(done)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, xb;
      xb = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one schedule against rk[]; observed keys land in obs[], cyc counts handshake cycles.
  task automatic run_schedule(input logic [127:0] lk, input int stall_pct, input bit poke_start,
                              input string tag, output int cyc);
    int idx;
    logic [133:0] exp_v;
    start = 1'b1; last_key = lk; key_ready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 0; idx = 10;
    while (idx >= 0 && cyc < 300) begin
      exp_v = {1'b1, 1'b1, idx[3:0], rk[idx]};
      total++;
      if ({key_valid, busy, round_out, key_out} !== exp_v) begin
        bad++;
        $display("FAIL %s key idx=%0d: got v=%b b=%b r=%0d k=%h want r=%0d k=%h",
                 tag, idx, key_valid, busy, round_out, key_out, idx, rk[idx]);
      end
      obs[idx] = key_out;
      key_ready = ($urandom_range(99) >= stall_pct);
      if (poke_start && idx == 6) begin start = 1'b1; last_key = ~lk; end
      tick();
      start = 1'b0;
      cyc++;
      if (key_ready) idx--;
    end
    key_ready = 1'b0;
    if (idx >= 0) begin
      total++; bad++;
      $display("FAIL %s timeout: stuck at idx=%0d want all 11 keys", tag, idx);
    end
    total++;
    if ({key_valid, busy, done} !== 3'b001) begin
      bad++;
      $display("FAIL %s done_pulse: got v/b/d=%b want 001", tag, {key_valid, busy, done});
    end
    tick();
    total++;
    if ({key_valid, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL %s after_done: got v/b/d=%b want 000", tag, {key_valid, busy, done});
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'($urandom); key_ready = 1'($urandom);
      last_key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      total++;
      if ({key_out, round_out, key_valid, busy, done} !== '0) begin
        bad++;
        $display("FAIL reset_hold: got k=%h r=%0d v=%b b=%b d=%b want all 0",
                 key_out, round_out, key_valid, busy, done);
      end
    end
    start = 1'b0; key_ready = 1'b1;
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({key_valid, busy, done} !== 3'b000) begin
        bad++;
        $display("FAIL reset_idle: got v/b/d=%b want 000", {key_valid, busy, done});
      end
    end
  endtask

  task automatic test_fips();
    int cyc;
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_schedule(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, 1'b0, "fips", cyc);
    total++;
    if (cyc != 11) begin bad++; $display("FAIL fips_cycles: got %0d want 11", cyc); end
    total++;
    if (obs[9] !== 128'hac7766f319fadc2128d12941575c006e) begin
      bad++; $display("FAIL fips_r9: got %h want ac7766f319fadc2128d12941575c006e", obs[9]);
    end
    total++;
    if (obs[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      bad++; $display("FAIL fips_r1: got %h want a0fafe1788542cb123a339392a6c7605", obs[1]);
    end
    total++;
    if (obs[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      bad++; $display("FAIL fips_r0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", obs[0]);
    end
  endtask

  task automatic test_stalls();
    int cyc;
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int i = 0; i < 3; i++) run_schedule(rk[10], 40, 1'b0, "stall", cyc);
  endtask

  task automatic test_start_ignored();
    int cyc;
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_schedule(rk[10], 20, 1'b1, "start_busy", cyc);
  endtask

  task automatic test_reset_mid();
    int cyc, guard;
    expand(128'h000102030405060708090a0b0c0d0e0f);
    start = 1'b1; last_key = rk[10]; key_ready = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (round_out != 4'd5 && guard < 50) begin tick(); guard++; end
    if (guard >= 50) begin
      total++; bad++; $display("FAIL rst_mid_reach: round 5 never seen, round=%0d", round_out);
    end
    #2 n_rst = 1'b0;
    #1;
    total++;
    if ({key_out, round_out, key_valid, busy, done} !== '0) begin
      bad++;
      $display("FAIL rst_mid_clear: got k=%h r=%0d v=%b b=%b d=%b want all 0",
               key_out, round_out, key_valid, busy, done);
    end
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({key_valid, busy, done} !== 3'b000) begin
        bad++; $display("FAIL rst_mid_quiet: got v/b/d=%b want 000", {key_valid, busy, done});
      end
    end
    run_schedule(rk[10], 0, 1'b0, "rst_replay", cyc);
  endtask

  task automatic test_random_keys();
    int cyc;
    for (int n = 0; n < 100; n++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      run_schedule(rk[10], $urandom_range(50), 1'b0, "random", cyc);
    end
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; key_ready = 1'b0; last_key = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_stalls();
    test_start_ignored();
    test_reset_mid();
    test_random_keys();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
